reg_wb_arbiter: RTL and testbench
=================================

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of write-back requesters (2..4).
REQ-002 SHALL have parameter NUM_REGISTERS, default 16, register-file depth; ADDR_W=4, DATA_W=8 fixed.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk  input  1  clock, rising edge.
REQ-005 SHALL have port reset  input  1  async active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester write request.
REQ-007 SHALL have port req_addr  input  NUM_REQ x 4  target register per requester.
REQ-008 SHALL have port req_data  input  NUM_REQ x 8  write data per requester.
REQ-009 SHALL have port req_ready  output  NUM_REQ  grant; transfer when valid&&ready at clk edge.
REQ-010 SHALL have port claim_valid, claim_addr  input  1, 4  issue stage marks a register as pending.
REQ-011 SHALL have port chk_addr1, chk_addr2  input  4, 4  source registers to hazard-check.
REQ-012 SHALL have port hazard1, hazard2  output  1, 1  source register has a pending write.
REQ-013 SHALL have port clr_start  input  1  request zeroing of all registers.
REQ-014 SHALL have port clr_busy  output  1  clear sequence in progress.
REQ-015 SHALL have port wr_en, wr_addr, wr_data  output  1, 4, 8  registered drive of register-file write port.

Function
REQ-016 SHALL have FSM states IDLE, CLEAR; IDLE->CLEAR on clr_start sampled in IDLE; CLEAR->IDLE after writing register 15.
REQ-017 SHALL in IDLE assert req_ready combinationally for at most one requester with req_valid high, none when no valid.
REQ-018 SHALL on a handshake load wr_en=1, wr_addr, wr_data from the granted requester at that edge (latency 1 cycle); otherwise wr_en=0 next cycle.
REQ-019 SHALL hold req_ready all-zero in CLEAR and in the IDLE cycle where clr_start is high (clear wins).
REQ-020 SHALL in CLEAR load wr_en=1, wr_addr=cnt, wr_data=0 each edge, cnt 0..15; wr_addr 0..15 appear on the 16 cycles following entry.
REQ-021 SHALL keep clr_busy high exactly 16 cycles (state==CLEAR); clr_start during CLEAR is ignored.
REQ-022 SHALL keep a pending bit per register: claim sets it, handshake to that address clears it.
REQ-023 SHALL, on same-edge claim and handshake to one address, leave the bit set (new producer wins).
REQ-024 SHALL clear all pending bits on entry to CLEAR and ignore claims while in CLEAR.
REQ-025 SHALL drive hazardN = pending[chk_addrN] combinationally; claim/handshake effects visible from the next cycle.

Reset
REQ-026 SHALL on reset assert: state IDLE, cnt 0, pending 0, round-robin pointer NUM_REQ-1, wr_en 0, wr_addr 0, wr_data 0.
REQ-027 SHALL abort a clear in progress on reset without further writes.

Configuration
REQ-028 SHALL with RR_ARB_EN defined grant round-robin: search from last-granted+1, wrapping; pointer updates only on handshake.
REQ-029 SHALL without RR_ARB_EN grant fixed priority, requester 0 highest; pointer logic absent.

Structure
REQ-030 SHALL place NUM_REGISTERS, ADDR_W, DATA_W and the state enum type in shared package reg_pkg.
REQ-031 SHALL implement grant selection in sub-module rr_arbiter (combinational grant, registered pointer).

Verification
REQ-032 SHALL cover: req0 valid addr 5 data 0x3C alone -> ready0 high, next cycle wr_en=1, wr_addr=5, wr_data=0x3C.
REQ-033 SHALL cover: all three valid continuously, RR_ARB_EN -> grants 0,1,2,0; without macro -> grants 0,0,0.
REQ-034 SHALL cover: claim addr 7, chk_addr1=7 -> hazard1=1 next cycle; req1 writes 7 -> hazard1=0 cycle after handshake.
REQ-035 SHALL cover: claim addr 3 and handshake to addr 3 same edge -> hazard on 3 stays 1.
REQ-036 SHALL cover: clr_start with req0 valid -> no ready, clr_busy 16 cycles, wr_addr 0..15 data 0, then req0 granted.
REQ-037 SHALL cover: reset asserted at clear cycle 8 -> wr_en 0 immediately, clr_busy 0, pending all 0.

Source files
------------

// File: rtl/reg_pkg.sv
// Shared definitions for the register write-back arbiter: register-file
// geometry and the controller state type.
package reg_pkg;
  localparam int NUM_REGISTERS = 16;
  localparam int ADDR_W        = 4;
  localparam int DATA_W        = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Grant selection for the write-back requesters. Grant is combinational
// from the request vector. With RR_ARB_EN defined the search starts one past
// the last granted requester and wraps; the pointer advances only when a
// grant is issued. Without RR_ARB_EN requester 0 has the highest priority
// and no pointer exists.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);
`ifdef RR_ARB_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // first valid requester after the last granted one, wrapping around
  always_comb begin
    int   c;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c = int'(ptr_q) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!found && en_i && req_i[IDX_W'(c)]) begin
        found               = 1'b1;
        gnt_o[IDX_W'(c)]    = 1'b1;
        idx_o               = IDX_W'(c);
      end
    end
  end

  // pointer follows the requester that actually transferred
  always_comb ptr_d = (|gnt_o) ? idx_o : ptr_q;

  // pointer register; after reset requester 0 is searched first
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= IDX_W'(NUM_REQ - 1);
    else       ptr_q <= ptr_d;
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk_i ^ rst_i;

  // lowest-index valid requester wins
  always_comb begin
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && en_i && req_i[i]) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
  end
`endif
endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-back arbiter with scoreboard and bulk clear.
// Several requesters compete for one registered write port; an issue-stage
// scoreboard tracks registers with writes still in flight; a clear sequence
// zeroes every register. Optional macro RR_ARB_EN selects round-robin
// arbitration instead of fixed priority.
module reg_wb_arbiter import reg_pkg::*; #(
  parameter int NUM_REQ       = 3,
  parameter int NUM_REGISTERS = reg_pkg::NUM_REGISTERS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           claim_valid,
  input  logic [ADDR_W-1:0]              claim_addr,
  input  logic [ADDR_W-1:0]              chk_addr1,
  input  logic [ADDR_W-1:0]              chk_addr2,
  output logic                           hazard1,
  output logic                           hazard2,
  input  logic                           clr_start,
  output logic                           clr_busy,
  output logic                           wr_en,
  output logic [ADDR_W-1:0]              wr_addr,
  output logic [DATA_W-1:0]              wr_data
);
  localparam int                IDX_W = $clog2(NUM_REQ);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGISTERS - 1);

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        cnt_q, cnt_d;
  logic [NUM_REGISTERS-1:0] pend_q, pend_d;
  logic                     wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]        wr_data_q, wr_data_d;

  logic                     grant_en;
  logic                     hs;
  logic [NUM_REQ-1:0]       gnt;
  logic [IDX_W-1:0]         gidx;

  // a pending clear request beats any write-back in the same cycle
  assign grant_en = (state_q == IDLE) && !clr_start;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .clk_i (clk),
    .rst_i (reset),
    .en_i  (grant_en),
    .req_i (req_valid),
    .gnt_o (gnt),
    .idx_o (gidx)
  );

  // grant only goes to a valid requester, so any grant is a transfer
  assign req_ready = gnt;
  assign hs        = |gnt;
  assign clr_busy  = (state_q == CLEAR);
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

  // state and clear-counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: clear walks every register once, then returns to IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (clr_start) state_d = CLEAR;
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // write-port drive: zeros while clearing, granted requester otherwise
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = '0;
      end
      default: begin
        if (hs) begin
          wr_en_d   = 1'b1;
          wr_addr_d = req_addr[gidx];
          wr_data_d = req_data[gidx];
        end
      end
    endcase
  end

  // registered write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // scoreboard update; a same-edge claim outranks the retiring write
  always_comb begin
    pend_d = pend_q;
    if (state_q == IDLE) begin
      if (clr_start) begin
        pend_d = '0;
      end else begin
        for (int i = 0; i < NUM_REGISTERS; i++) begin
          if (hs && req_addr[gidx] == ADDR_W'(i)) pend_d[i] = 1'b0;
          if (claim_valid && claim_addr == ADDR_W'(i)) pend_d[i] = 1'b1;
        end
      end
    end
  end

  // scoreboard register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  // hazard lookup; out-of-range addresses never report a hazard
  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    for (int i = 0; i < NUM_REGISTERS; i++) begin
      if (chk_addr1 == ADDR_W'(i)) hazard1 = pend_q[i];
      if (chk_addr2 == ADDR_W'(i)) hazard2 = pend_q[i];
    end
  end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_reg_wb_arbiter;
  localparam int NR = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0][3:0] req_addr;
  logic [NR-1:0][7:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             claim_valid;
  logic [3:0]       claim_addr, chk_addr1, chk_addr2;
  logic             hazard1, hazard2;
  logic             clr_start, clr_busy;
  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [7:0]       wr_data;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit m_clr;
  int m_left;
  bit m_pend [16];
  int m_ptr;
  bit m_wr_en;
  int m_wr_addr, m_wr_data;

  reg_wb_arbiter #(.NUM_REQ(NR), .NUM_REGISTERS(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .claim_valid(claim_valid), .claim_addr(claim_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .hazard1(hazard1), .hazard2(hazard2),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_addr = '0; req_data = '0;
    claim_valid = 1'b0; claim_addr = '0;
    chk_addr1 = '0; chk_addr2 = '0; clr_start = 1'b0;
  endtask

  task automatic model_reset();
    m_clr = 0; m_left = 0; m_ptr = NR - 1;
    m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0;
    for (int i = 0; i < 16; i++) m_pend[i] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  // which requester the rules say is granted this cycle (-1: none)
  function automatic int exp_grant();
    if (m_clr || clr_start) return -1;
`ifdef RR_ARB_EN
    for (int k = 1; k <= NR; k++) if (req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
`else
    for (int k = 0; k < NR; k++) if (req_valid[k]) return k;
`endif
    return -1;
  endfunction

  // apply one clock edge to the model using the currently driven inputs
  task automatic model_edge();
    int g;
    g = exp_grant();
    if (m_clr) begin
      m_wr_en = 1; m_wr_addr = 16 - m_left; m_wr_data = 0;
      m_left--;
      if (m_left == 0) m_clr = 0;
    end else if (clr_start) begin
      m_clr = 1; m_left = 16; m_wr_en = 0;
      for (int i = 0; i < 16; i++) m_pend[i] = 0;
    end else begin
      if (g >= 0) begin
        m_wr_en = 1; m_wr_addr = req_addr[g]; m_wr_data = req_data[g];
        m_pend[req_addr[g]] = 0;
        m_ptr = g;
      end else begin
        m_wr_en = 0;
      end
      if (claim_valid) m_pend[claim_addr] = 1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if (wr_en !== 1'b0 || wr_addr !== 4'd0 || wr_data !== 8'd0 || clr_busy !== 1'b0 || req_ready !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%h busy=%b ready=%b want 0/0/00/0/000",
               wr_en, wr_addr, wr_data, clr_busy, req_ready);
    end
    for (int i = 0; i < 16; i++) begin
      chk_addr1 = 4'(i); chk_addr2 = 4'(15 - i);
      #1;
      n_cmp++;
      if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_pending[%0d]: got h1=%b h2=%b want 0/0", i, hazard1, hazard2);
      end
    end
  endtask

  task automatic test_single_write();
    do_reset();
    req_valid = 3'b001; req_addr[0] = 4'd5; req_data[0] = 8'h3C;
    #1;
    n_cmp++;
    if (req_ready !== 3'b001) begin
      n_bad++; $display("FAIL single_ready: got %b want 001", req_ready);
    end
    tick();
    req_valid = '0;
    n_cmp++;
    if (wr_en !== 1'b1 || wr_addr !== 4'd5 || wr_data !== 8'h3C) begin
      n_bad++;
      $display("FAIL single_write: got en=%b addr=%0d data=%h want 1/5/3c", wr_en, wr_addr, wr_data);
    end
    tick();
    n_cmp++;
    if (wr_en !== 1'b0) begin
      n_bad++; $display("FAIL single_idle_after: got en=%b want 0", wr_en);
    end
  endtask

  task automatic test_arbitration();
    int exp_seq [4];
`ifdef RR_ARB_EN
    exp_seq = '{0, 1, 2, 0};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    do_reset();
    req_valid = 3'b111;
    for (int i = 0; i < NR; i++) begin
      req_addr[i] = 4'(i + 1); req_data[i] = 8'(8'hA0 + i);
    end
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if (req_ready !== 3'(1 << exp_seq[k])) begin
        n_bad++;
        $display("FAIL arb_ready[%0d]: got %b want %b", k, req_ready, 3'(1 << exp_seq[k]));
      end
      tick();
      n_cmp++;
      if (wr_en !== 1'b1 || wr_addr !== 4'(exp_seq[k] + 1) || wr_data !== 8'(8'hA0 + exp_seq[k])) begin
        n_bad++;
        $display("FAIL arb_write[%0d]: got en=%b addr=%0d data=%h want requester %0d",
                 k, wr_en, wr_addr, wr_data, exp_seq[k]);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_hazard();
    do_reset();
    claim_valid = 1'b1; claim_addr = 4'd7; chk_addr1 = 4'd7; chk_addr2 = 4'd6;
    #1;
    n_cmp++;
    if (hazard1 !== 1'b0) begin
      n_bad++; $display("FAIL hazard_before_claim: got %b want 0", hazard1);
    end
    tick();
    claim_valid = 1'b0;
    #1;
    n_cmp++;
    if (hazard1 !== 1'b1 || hazard2 !== 1'b0) begin
      n_bad++; $display("FAIL hazard_after_claim: got h1=%b h2=%b want 1/0", hazard1, hazard2);
    end
    req_valid = 3'b010; req_addr[1] = 4'd7; req_data[1] = 8'h55;
    #1;
    n_cmp++;
    if (req_ready !== 3'b010 || hazard1 !== 1'b1) begin
      n_bad++; $display("FAIL hazard_handshake_cycle: got ready=%b h1=%b want 010/1", req_ready, hazard1);
    end
    tick();
    req_valid = '0;
    #1;
    n_cmp++;
    if (hazard1 !== 1'b0 || wr_en !== 1'b1 || wr_addr !== 4'd7 || wr_data !== 8'h55) begin
      n_bad++;
      $display("FAIL hazard_retired: got h1=%b en=%b addr=%0d data=%h want 0/1/7/55",
               hazard1, wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_same_edge();
    do_reset();
    chk_addr2 = 4'd3;
    claim_valid = 1'b1; claim_addr = 4'd3;
    tick();
    // second claim while the old producer retires on the same edge
    req_valid = 3'b001; req_addr[0] = 4'd3; req_data[0] = 8'h11;
    #1;
    n_cmp++;
    if (req_ready !== 3'b001 || hazard2 !== 1'b1) begin
      n_bad++; $display("FAIL same_edge_setup: got ready=%b h2=%b want 001/1", req_ready, hazard2);
    end
    tick();
    claim_valid = 1'b0; req_valid = '0;
    #1;
    n_cmp++;
    if (hazard2 !== 1'b1) begin
      n_bad++; $display("FAIL same_edge_claim_wins: got h2=%b want 1", hazard2);
    end
  endtask

  task automatic test_clear();
    do_reset();
    claim_valid = 1'b1; claim_addr = 4'd9; chk_addr1 = 4'd9;
    tick();
    claim_valid = 1'b0;
    clr_start = 1'b1; req_valid = 3'b001; req_addr[0] = 4'd5; req_data[0] = 8'h3C;
    #1;
    n_cmp++;
    if (req_ready !== 3'b000 || clr_busy !== 1'b0 || hazard1 !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_start_cycle: got ready=%b busy=%b h1=%b want 000/0/1", req_ready, clr_busy, hazard1);
    end
    tick();
    clr_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      clr_start = (k == 4);
      claim_valid = (k == 6);
      #1;
      n_cmp++;
      if (clr_busy !== 1'b1 || req_ready !== 3'b000 || hazard1 !== 1'b0) begin
        n_bad++;
        $display("FAIL clear_busy[%0d]: got busy=%b ready=%b h1=%b want 1/000/0", k, clr_busy, req_ready, hazard1);
      end
      tick();
      n_cmp++;
      if (wr_en !== 1'b1 || wr_addr !== 4'(k) || wr_data !== 8'h00) begin
        n_bad++;
        $display("FAIL clear_write[%0d]: got en=%b addr=%0d data=%h want 1/%0d/00", k, wr_en, wr_addr, wr_data, k);
      end
    end
    clr_start = 1'b0; claim_valid = 1'b0;
    #1;
    n_cmp++;
    if (clr_busy !== 1'b0 || req_ready !== 3'b001 || hazard1 !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_done: got busy=%b ready=%b h1=%b want 0/001/0", clr_busy, req_ready, hazard1);
    end
    tick();
    req_valid = '0;
    n_cmp++;
    if (wr_en !== 1'b1 || wr_addr !== 4'd5 || wr_data !== 8'h3C) begin
      n_bad++;
      $display("FAIL clear_then_grant: got en=%b addr=%0d data=%h want 1/5/3c", wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (8) tick();
    n_cmp++;
    if (clr_busy !== 1'b1 || wr_addr !== 4'd7) begin
      n_bad++; $display("FAIL midclear_progress: got busy=%b addr=%0d want 1/7", clr_busy, wr_addr);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (wr_en !== 1'b0 || clr_busy !== 1'b0 || wr_addr !== 4'd0) begin
      n_bad++;
      $display("FAIL midclear_reset: got en=%b busy=%b addr=%0d want 0/0/0", wr_en, clr_busy, wr_addr);
    end
    for (int i = 0; i < 16; i++) begin
      chk_addr1 = 4'(i);
      #1;
      n_cmp++;
      if (hazard1 !== 1'b0) begin
        n_bad++; $display("FAIL midclear_pending[%0d]: got %b want 0", i, hazard1);
      end
    end
    tick();
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (wr_en !== 1'b0 || clr_busy !== 1'b0) begin
        n_bad++; $display("FAIL midclear_no_resume[%0d]: got en=%b busy=%b want 0/0", k, wr_en, clr_busy);
      end
    end
  endtask

  task automatic test_random();
    int g;
    logic [NR-1:0] er;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid = 3'($urandom_range(0, 7));
      for (int i = 0; i < NR; i++) begin
        req_addr[i] = 4'($urandom_range(0, 15));
        req_data[i] = 8'($urandom_range(0, 255));
      end
      claim_valid = ($urandom_range(0, 2) == 0);
      claim_addr  = 4'($urandom_range(0, 15));
      chk_addr1   = 4'($urandom_range(0, 15));
      chk_addr2   = 4'($urandom_range(0, 15));
      clr_start   = ($urandom_range(0, 39) == 0);
      #1;
      g  = exp_grant();
      er = (g < 0) ? '0 : NR'(1 << g);
      n_cmp++;
      if (req_ready !== er || clr_busy !== m_clr || hazard1 !== m_pend[chk_addr1] || hazard2 !== m_pend[chk_addr2]) begin
        n_bad++;
        $display("FAIL rand_comb[%0d]: got ready=%b busy=%b h1=%b h2=%b want %b/%b/%b/%b",
                 cyc, req_ready, clr_busy, hazard1, hazard2, er, m_clr, m_pend[chk_addr1], m_pend[chk_addr2]);
      end
      model_edge();
      tick();
      n_cmp++;
      if (wr_en !== m_wr_en || (m_wr_en && (wr_addr !== 4'(m_wr_addr) || wr_data !== 8'(m_wr_data)))) begin
        n_bad++;
        $display("FAIL rand_write[%0d]: got en=%b addr=%0d data=%h want %b/%0d/%h",
                 cyc, wr_en, wr_addr, wr_data, m_wr_en, m_wr_addr, m_wr_data);
      end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_single_write();
    test_arbitration();
    test_hazard();
    test_same_edge();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
